// File: rtl/turf_rr_arb.sv
// turf_rr_arb: N-master register-bus arbiter with a per-transaction ack watchdog.
// Masters request with en/wr/adr/dat. The single winner is forwarded to the
// register core. Its ack or a watchdog timeout is returned as a one-cycle pulse.
`timescale 1ns/1ps
module turf_rr_arb #(
   parameter int            NMASTER       = 2,
   parameter int            AW            = 28,
   parameter int            DW            = 32,
   parameter int            PRIORITY_MODE = 0,
   parameter int            TIMEOUT       = 1024,
   parameter logic [DW-1:0] TIMEOUT_DATA  = DW'(32'hDEADBEEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NMASTER-1:0]    s_en_i,
   input  logic [NMASTER-1:0]    s_wr_i,
   input  logic [NMASTER*AW-1:0] s_adr_i,
   input  logic [NMASTER*DW-1:0] s_dat_i,
   output logic [NMASTER-1:0]    s_ack_o,
   output logic [NMASTER-1:0]    s_err_o,
   output logic [NMASTER*DW-1:0] s_dat_o,
   output logic                  m_en_o,
   output logic                  m_wr_o,
   output logic [AW-1:0]         m_adr_o,
   output logic [DW-1:0]         m_dat_o,
   input  logic                  m_ack_i,
   input  logic [DW-1:0]         m_dat_i,
   output logic [NMASTER-1:0]    grant_o,
   output logic [15:0]           timeout_count_o
);

   localparam int GW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
   localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [GW-1:0]           gidx_q, gidx_d;
   logic [GW-1:0]           last_q, last_d;
   logic [NMASTER-1:0]      grant_q, grant_d;
   logic [WW-1:0]           wd_q, wd_d;
   logic                    m_en_q, m_en_d;
   logic                    m_wr_q, m_wr_d;
   logic [AW-1:0]           m_adr_q, m_adr_d;
   logic [DW-1:0]           m_dat_q, m_dat_d;
   logic [NMASTER-1:0]      ack_q, ack_d;
   logic [NMASTER-1:0]      err_q, err_d;
   logic [NMASTER*DW-1:0]   sdat_q, sdat_d;
   logic [15:0]             tcnt_q, tcnt_d;

   logic [GW-1:0]           win_idx;
   logic                    win_vld;
   logic [GW-1:0]           cand;
   int unsigned             cand_full;

   // Winner selection: fixed priority scans from index 0, round-robin scans from last_grant+1 with wrap.
   always_comb begin
      win_idx   = '0;
      win_vld   = 1'b0;
      cand      = '0;
      cand_full = 0;
      if (PRIORITY_MODE != 0) begin
         for (int unsigned i = 0; i < NMASTER; i++) begin
            cand = GW'(i);
            if (!win_vld && s_en_i[cand]) begin
               win_idx = cand;
               win_vld = 1'b1;
            end
         end
      end else begin
         for (int unsigned off = 1; off <= NMASTER; off++) begin
            cand_full = (int'(last_q) + off) % NMASTER;
            cand      = GW'(cand_full);
            if (!win_vld && s_en_i[cand]) begin
               win_idx = cand;
               win_vld = 1'b1;
            end
         end
      end
   end

   // Next-state and registered-output logic for IDLE -> BUSY -> ACK.
   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      grant_d = grant_q;
      wd_d    = wd_q;
      m_en_d  = m_en_q;
      m_wr_d  = m_wr_q;
      m_adr_d = m_adr_q;
      m_dat_d = m_dat_q;
      ack_d   = '0;
      err_d   = '0;
      sdat_d  = sdat_q;
      tcnt_d  = tcnt_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = BUSY;
               gidx_d  = win_idx;
               last_d  = win_idx;
               wd_d    = '0;
               m_en_d  = 1'b1;
               for (int unsigned i = 0; i < NMASTER; i++) begin
                  grant_d[i] = (GW'(i) == win_idx);
                  if (GW'(i) == win_idx) begin
                     m_wr_d  = s_wr_i[i];
                     m_adr_d = s_adr_i[i*AW +: AW];
                     m_dat_d = s_dat_i[i*DW +: DW];
                  end
               end
            end
         end
         BUSY: begin
            wd_d = wd_q + 1'b1;
            if (m_ack_i) begin
               state_d = ACK;
               m_en_d  = 1'b0;
               ack_d   = grant_q;
               for (int unsigned i = 0; i < NMASTER; i++) begin
                  if (GW'(i) == gidx_q) sdat_d[i*DW +: DW] = m_dat_i;
               end
            end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
               state_d = ACK;
               m_en_d  = 1'b0;
               ack_d   = grant_q;
               err_d   = grant_q;
               if (tcnt_q != '1) tcnt_d = tcnt_q + 16'd1;
               for (int unsigned i = 0; i < NMASTER; i++) begin
                  if (GW'(i) == gidx_q) sdat_d[i*DW +: DW] = TIMEOUT_DATA;
               end
            end
         end
         ACK: begin
            state_d = IDLE;
            grant_d = '0;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            m_en_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gidx_q  <= '0;
         last_q  <= GW'(NMASTER - 1);
         grant_q <= '0;
         wd_q    <= '0;
         m_en_q  <= 1'b0;
         m_wr_q  <= 1'b0;
         m_adr_q <= '0;
         m_dat_q <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         sdat_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         wd_q    <= wd_d;
         m_en_q  <= m_en_d;
         m_wr_q  <= m_wr_d;
         m_adr_q <= m_adr_d;
         m_dat_q <= m_dat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         sdat_q  <= sdat_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign s_ack_o         = ack_q;
   assign s_err_o         = err_q;
   assign s_dat_o         = sdat_q;
   assign m_en_o          = m_en_q;
   assign m_wr_o          = m_wr_q;
   assign m_adr_o         = m_adr_q;
   assign m_dat_o         = m_dat_q;
   assign grant_o         = grant_q;
   assign timeout_count_o = tcnt_q;

endmodule
